// File: rtl/mem_wb_stage.sv
// MEM->WB stage: extends load data at enqueue, buffers results in a 2-entry skid FIFO,
// and drives the register-file write port from the head entry.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MEM_VALID,
  output logic              MEM_READY,
  input  logic              MEM_WEN,
  input  logic [ADDR_W-1:0] MEM_WADDR,
  input  logic [DATA_W-1:0] MEM_ALU,
  input  logic              MEM_IS_LOAD,
  input  logic [2:0]        MEM_LOAD_OP,
  input  logic [1:0]        MEM_BYTE_OFF,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              WB_STALL,
  input  logic              FLUSH,
  output logic              WB_WEN,
  output logic [ADDR_W-1:0] WB_WADDR,
  output logic [DATA_W-1:0] WB_WDATA,
  output logic              MISALIGN,
  output logic [31:0]       RETIRE_CNT
);

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } ent_t;

  localparam logic [2:0] OP_LB = 3'd0, OP_LBU = 3'd1, OP_LH = 3'd2, OP_LHU = 3'd3, OP_LW = 3'd4;

  ent_t       ent_q [2];
  logic [1:0] cnt_q;
  logic       mis_q;
  logic [31:0] rcnt_q;

  logic        accept, retire, head_vld, wr_idx, mis;
  logic [7:0]  byte_k;
  logic [15:0] half_k;
  ent_t        new_ent;

  assign head_vld  = (cnt_q != 2'd0);
  assign MEM_READY = (cnt_q < 2'(DEPTH));
  assign accept    = MEM_VALID && MEM_READY && !FLUSH;
  assign retire    = head_vld && !WB_STALL && !FLUSH;
  // With one entry retiring in the same cycle, the new entry lands directly in the head slot.
  assign wr_idx    = (cnt_q == 2'd1) && !retire;

  assign byte_k = MEM_RDATA[8*MEM_BYTE_OFF +: 8];
  assign half_k = MEM_BYTE_OFF[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];

  always_comb begin
    mis           = 1'b0;
    new_ent.wen   = MEM_WEN;
    new_ent.waddr = MEM_WADDR;
    new_ent.wdata = MEM_ALU;
    if (MEM_IS_LOAD) begin
      case (MEM_LOAD_OP)
        OP_LB:  new_ent.wdata = {{(DATA_W-8){byte_k[7]}}, byte_k};
        OP_LBU: new_ent.wdata = {{(DATA_W-8){1'b0}}, byte_k};
        OP_LH:  begin
          new_ent.wdata = {{(DATA_W-16){half_k[15]}}, half_k};
          mis = MEM_BYTE_OFF[0];
        end
        OP_LHU: begin
          new_ent.wdata = {{(DATA_W-16){1'b0}}, half_k};
          mis = MEM_BYTE_OFF[0];
        end
        OP_LW:  begin
          new_ent.wdata = MEM_RDATA;
          mis = (MEM_BYTE_OFF != 2'd0);
        end
        default: mis = 1'b1;
      endcase
      if (mis) new_ent.wen = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q  <= 2'd0;
      mis_q  <= 1'b0;
      rcnt_q <= 32'd0;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      mis_q <= accept && mis;
      if (FLUSH) begin
        cnt_q <= 2'd0;
      end else begin
        if (retire) begin
          ent_q[0] <= ent_q[1];
          rcnt_q   <= rcnt_q + 32'd1;
        end
        if (accept) ent_q[wr_idx] <= new_ent;
        case ({accept, retire})
          2'b10:   cnt_q <= cnt_q + 2'd1;
          2'b01:   cnt_q <= cnt_q - 2'd1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  assign WB_WEN     = head_vld && ent_q[0].wen && (ent_q[0].waddr != '0) && !WB_STALL && !FLUSH;
  assign WB_WADDR   = head_vld ? ent_q[0].waddr : '0;
  assign WB_WDATA   = head_vld ? ent_q[0].wdata : '0;
  assign MISALIGN   = mis_q;
  assign RETIRE_CNT = rcnt_q;

endmodule
